// File: rtl/xrv_bus_pkg.sv
// Shared types and constants for the core data-port to APB bridge.
package xrv_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } bus_state_e;

    localparam logic [2:0]  APB_PROT_DEFAULT  = 3'b000;
    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/xrv_bus_timeout.sv
// ACCESS-phase cycle counter. Cleared when a transfer starts, counts while
// enabled and saturates instead of wrapping. TIMEOUT=0 disables expiry.
module xrv_bus_timeout #(
    parameter int TIMEOUT = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Next count: clear has priority, then saturating increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Expiry is flagged on the last allowed ACCESS cycle so the FSM aborts
    // after exactly TIMEOUT cycles of waiting.
    assign expired_o = (TIMEOUT != 0) && en_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/xrv_dbus_apb.sv
// Bridge from the core data port to an APB4 master. Each request is latched,
// run through SETUP/ACCESS with wait states and a timeout, and answered with
// a one-cycle ready pulse plus registered read data.
module xrv_dbus_apb
    import xrv_bus_pkg::*;
#(
    parameter int          AW        = 32,
    parameter int          TIMEOUT   = 256,
    parameter logic [31:0] ERR_RDATA = ERR_RDATA_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   d_addr,
    input  logic          d_wr_req,
    input  logic          d_rd_req,
    input  logic [3:0]    d_be,
    input  logic [31:0]   d_wr_data,
    output logic          d_wr_ready,
    output logic          d_rd_ready,
    output logic [31:0]   d_rd_data,
    output logic [AW-1:0] paddr,
    output logic          psel,
    output logic          penable,
    output logic          pwrite,
    output logic [31:0]   pwdata,
    output logic [3:0]    pstrb,
    output logic [2:0]    pprot,
    input  logic [31:0]   prdata,
    input  logic          pready,
    input  logic          pslverr,
    output logic          bus_err,
    output logic [31:0]   bus_err_addr
);

    bus_state_e  state_q, state_d;
    logic [31:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic        wr_q;
    logic        err_q, err_d;
    logic [31:0] rdata_q;
    logic [31:0] eaddr_q;
    logic        accept;
    logic        finish;
    logic        expired;

    xrv_bus_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (accept),
        .en_i      (state_q == ST_ACCESS),
        .expired_o (expired)
    );

    // Next-state logic; pready takes priority over a coincident timeout.
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        accept  = 1'b0;
        finish  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (d_wr_req || d_rd_req) begin
                    accept  = 1'b1;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (pready) begin
                    finish  = 1'b1;
                    err_d   = pslverr;
                    state_d = ST_DONE;
                end else if (expired) begin
                    finish  = 1'b1;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request latch, completion status, read data and error address.
    // A simultaneous read is simply not latched; it is seen again in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            eaddr_q <= '0;
        end else begin
            err_q <= err_d;
            if (accept) begin
                addr_q  <= d_addr;
                be_q    <= d_be;
                wdata_q <= d_wr_data;
                wr_q    <= d_wr_req;
            end
            if (finish) begin
                if (!wr_q) begin
                    rdata_q <= err_d ? ERR_RDATA : prdata;
                end
                if (err_d) begin
                    eaddr_q <= addr_q;
                end
            end
        end
    end

    assign psel         = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    assign penable      = (state_q == ST_ACCESS);
    assign paddr        = addr_q[AW-1:0];
    assign pwrite       = wr_q;
    assign pstrb        = wr_q ? be_q : 4'b0000;
    assign pwdata       = wr_q ? wdata_q : 32'h0;
    assign pprot        = APB_PROT_DEFAULT;
    assign d_wr_ready   = (state_q == ST_DONE) && wr_q;
    assign d_rd_ready   = (state_q == ST_DONE) && !wr_q;
    assign bus_err      = (state_q == ST_DONE) && err_q;
    assign d_rd_data    = rdata_q;
    assign bus_err_addr = eaddr_q;

endmodule

// File: tb/tb_xrv_dbus_apb.sv
// Bench for xrv_dbus_apb: per-transfer plan of expected per-cycle outputs,
// compared every cycle, plus hand-computed literal checks.
module tb_xrv_dbus_apb;

    localparam int TO = 4;
    localparam int NC = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] d_addr = '0;
    logic        d_wr_req = 1'b0;
    logic        d_rd_req = 1'b0;
    logic [3:0]  d_be = '0;
    logic [31:0] d_wr_data = '0;
    logic        d_wr_ready, d_rd_ready;
    logic [31:0] d_rd_data;
    logic [31:0] paddr;
    logic        psel, penable, pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic [31:0] prdata = '0;
    logic        pready = 1'b0;
    logic        pslverr = 1'b0;
    logic        bus_err;
    logic [31:0] bus_err_addr;

    xrv_dbus_apb #(.AW(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .d_addr(d_addr), .d_wr_req(d_wr_req),
        .d_rd_req(d_rd_req), .d_be(d_be), .d_wr_data(d_wr_data),
        .d_wr_ready(d_wr_ready), .d_rd_ready(d_rd_ready), .d_rd_data(d_rd_data),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
        .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot), .prdata(prdata),
        .pready(pready), .pslverr(pslverr), .bus_err(bus_err),
        .bus_err_addr(bus_err_addr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected per-cycle outputs (0 = bus idle)
    bit          e_psel [NC];
    bit          e_pen  [NC];
    bit          e_pwr  [NC];
    bit          e_wrdy [NC];
    bit          e_rrdy [NC];
    bit          e_err  [NC];
    bit          e_rst  [NC];
    logic [31:0] e_addr [NC];
    logic [31:0] e_wdat [NC];
    logic [3:0]  e_strb [NC];
    logic [31:0] e_rdat [NC];

    int          n_chk = 0;
    int          n_fail = 0;
    bit          chk_en = 1'b0;
    logic [31:0] m_rdata = '0;
    logic [31:0] m_eaddr = '0;
    int          last_rdy = -1;
    int          last_err = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Lay out one transfer accepted at cycle c0: SETUP, acc ACCESS cycles,
    // then a DONE cycle with the ready pulse.
    task automatic plan(input int c0, input bit wr, input logic [31:0] a,
                        input logic [3:0] be, input logic [31:0] wd, input int waits,
                        input bit serr, input logic [31:0] rd, output int acc);
        bit to;
        int dn;
        to  = (TO > 0) && (waits + 1 > TO);
        acc = to ? TO : waits + 1;
        for (int t = c0 + 1; t <= c0 + 1 + acc; t++) begin
            e_psel[t] = 1'b1;
            e_pen[t]  = (t >= c0 + 2);
            e_addr[t] = a;
            e_pwr[t]  = wr;
            e_strb[t] = wr ? be : 4'h0;
            e_wdat[t] = wr ? wd : 32'h0;
        end
        dn = c0 + 2 + acc;
        e_wrdy[dn] = wr;
        e_rrdy[dn] = !wr;
        e_err[dn]  = to || serr;
        e_addr[dn] = a;
        e_rdat[dn] = (to || serr) ? 32'hDEAD_BEEF : rd;
    endtask

    // Drive one transfer starting in the current (IDLE) cycle; returns in
    // the IDLE cycle after the ready pulse.
    task automatic do_txn(input bit wr, input logic [31:0] a, input logic [3:0] be,
                          input logic [31:0] wd, input int waits, input bit serr,
                          input logic [31:0] rd, input bit drop, input bit keep_rd,
                          output int c0);
        int acc;
        c0 = cyc;
        plan(c0, wr, a, be, wd, waits, serr, rd, acc);
        d_wr_req  = wr;
        d_rd_req  = !wr || keep_rd;
        d_addr    = a;
        d_be      = be;
        d_wr_data = wd;
        prdata    = rd;
        pready    = 1'b0;
        pslverr   = 1'b0;
        for (int t = 1; t <= acc + 2; t++) begin
            @(posedge clk); #1;
            if (drop) begin
                d_wr_req = 1'b0;
                d_rd_req = 1'b0;
            end
            pready  = (t - 2 == waits);
            pslverr = (t - 2 == waits) && serr;
        end
        @(posedge clk); #1;
        d_wr_req = 1'b0;
        d_rd_req = keep_rd;
        pready   = 1'b0;
        pslverr  = 1'b0;
    endtask

    initial begin
        int c0;
        fork
            forever begin
                @(negedge clk);
                if (chk_en) begin
                    if (e_rst[cyc]) begin
                        m_rdata = '0;
                        m_eaddr = '0;
                    end
                    if (e_rrdy[cyc]) m_rdata = e_rdat[cyc];
                    if (e_err[cyc])  m_eaddr = e_addr[cyc];
                    chk("psel", 32'(psel), 32'(e_psel[cyc]));
                    chk("penable", 32'(penable), 32'(e_pen[cyc]));
                    chk("d_wr_ready", 32'(d_wr_ready), 32'(e_wrdy[cyc]));
                    chk("d_rd_ready", 32'(d_rd_ready), 32'(e_rrdy[cyc]));
                    chk("bus_err", 32'(bus_err), 32'(e_err[cyc]));
                    chk("pprot", 32'(pprot), 32'h0);
                    chk("d_rd_data", d_rd_data, m_rdata);
                    chk("bus_err_addr", bus_err_addr, m_eaddr);
                    if (e_psel[cyc]) begin
                        chk("paddr", paddr, e_addr[cyc]);
                        chk("pwrite", 32'(pwrite), 32'(e_pwr[cyc]));
                        chk("pstrb", 32'(pstrb), 32'(e_strb[cyc]));
                        chk("pwdata", pwdata, e_wdat[cyc]);
                    end
                    if (d_wr_ready || d_rd_ready) last_rdy = cyc;
                    if (bus_err) last_err = cyc;
                end
            end
        join_none

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_psel", 32'(psel), 32'h0);
        chk("rst_penable", 32'(penable), 32'h0);
        chk("rst_ready", 32'({d_wr_ready, d_rd_ready, bus_err}), 32'h0);
        chk("rst_rdata", d_rd_data, 32'h0);
        chk("rst_eaddr", bus_err_addr, 32'h0);
        chk("rst_paddr", paddr, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk_en = 1'b1;

        // Zero-wait read
        do_txn(1'b0, 32'h1000_0004, 4'h0, 32'h0, 0, 1'b0, 32'h1234_5678, 1'b0, 1'b0, c0);
        chk("rd0_latency", 32'(last_rdy - c0), 32'd3);
        chk("rd0_data", d_rd_data, 32'h1234_5678);

        // Write with three wait states
        do_txn(1'b1, 32'h2000_0008, 4'b0110, 32'hA5A5_0F0F, 3, 1'b0, 32'h0, 1'b0, 1'b0, c0);
        chk("wr3_latency", 32'(last_rdy - c0), 32'd6);
        chk("wr3_rdata_kept", d_rd_data, 32'h1234_5678);

        // Read completing with pslverr
        do_txn(1'b0, 32'h3000_0010, 4'h0, 32'h0, 1, 1'b1, 32'h5555_AAAA, 1'b0, 1'b0, c0);
        chk("serr_latency", 32'(last_rdy - c0), 32'd4);
        chk("serr_rdata", d_rd_data, 32'hDEAD_BEEF);
        chk("serr_eaddr", bus_err_addr, 32'h3000_0010);

        // Read that times out after four ACCESS cycles
        do_txn(1'b0, 32'h4000_0020, 4'h0, 32'h0, 20, 1'b0, 32'h1111_1111, 1'b0, 1'b0, c0);
        chk("to_latency", 32'(last_rdy - c0), 32'd6);
        chk("to_err_with_ready", 32'(last_err), 32'(last_rdy));
        chk("to_rdata", d_rd_data, 32'hDEAD_BEEF);
        chk("to_eaddr", bus_err_addr, 32'h4000_0020);

        // Write with pslverr still acknowledged
        do_txn(1'b1, 32'h5000_0000, 4'hF, 32'h0102_0304, 0, 1'b1, 32'h0, 1'b0, 1'b0, c0);
        chk("wserr_eaddr", bus_err_addr, 32'h5000_0000);
        chk("wserr_rdata_kept", d_rd_data, 32'hDEAD_BEEF);

        // Write and read together: write first, read in the next IDLE
        do_txn(1'b1, 32'h6000_0004, 4'b1001, 32'h7777_8888, 0, 1'b0, 32'h0, 1'b0, 1'b1, c0);
        do_txn(1'b0, 32'h6000_0008, 4'h0, 32'h0, 0, 1'b0, 32'hCAFE_F00D, 1'b0, 1'b0, c0);
        chk("both_rd_latency", 32'(last_rdy - c0), 32'd3);
        chk("both_rd_data", d_rd_data, 32'hCAFE_F00D);

        // Request dropped after acceptance still completes
        do_txn(1'b0, 32'h7000_000C, 4'h0, 32'h0, 2, 1'b0, 32'h0BAD_CAFE, 1'b1, 1'b0, c0);
        chk("drop_latency", 32'(last_rdy - c0), 32'd5);
        chk("drop_rdata", d_rd_data, 32'h0BAD_CAFE);

        // Reset during ACCESS
        begin
            int acc;
            c0 = cyc;
            plan(c0, 1'b0, 32'h0800_0000, 4'h0, 32'h0, 20, 1'b0, 32'h0, acc);
            d_rd_req = 1'b1;
            d_addr   = 32'h0800_0000;
            pready   = 1'b0;
            repeat (3) begin
                @(posedge clk); #1;
            end
            chk("pre_rst_penable", 32'(penable), 32'h1);
            for (int t = c0 + 3; t <= c0 + 10; t++) begin
                e_psel[t] = 1'b0;
                e_pen[t]  = 1'b0;
                e_wrdy[t] = 1'b0;
                e_rrdy[t] = 1'b0;
                e_err[t]  = 1'b0;
            end
            e_rst[c0 + 3] = 1'b1;
            #1;
            rst      = 1'b1;
            d_rd_req = 1'b0;
            #1;
            chk("rst_async_psel", 32'(psel), 32'h0);
            chk("rst_async_penable", 32'(penable), 32'h0);
            @(posedge clk); #1;
            rst = 1'b0;
            @(posedge clk); #1;
        end
        do_txn(1'b0, 32'h0900_0004, 4'h0, 32'h0, 0, 1'b0, 32'h1357_9BDF, 1'b0, 1'b0, c0);
        chk("post_rst_latency", 32'(last_rdy - c0), 32'd3);
        chk("post_rst_rdata", d_rd_data, 32'h1357_9BDF);

        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
